// File: rtl/ram_pkg.sv
// Shared types and constants for the parameterised byte-enable RAM.
package ram_pkg;

  // Control FSM: clear the array after reset, then serve requests.
  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Same-address read-during-write policy selectors.
  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // Elaboration-time legality check for the RAM parameter set.
  function automatic bit params_ok(input int data_w, input int depth,
                                   input int addr_w, input int rd_lat);
    bit ok;
    ok = 1'b1;
    if ((data_w % 8) != 0 || data_w <= 0) ok = 1'b0;
    if (depth < 1 || depth > (1 << addr_w)) ok = 1'b0;
    if (rd_lat != 1 && rd_lat != 2) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Optional second read stage: registers data, valid and err by one cycle.
module ram_rd_pipe #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              err_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  output logic              err_out,
  output logic [DATA_W-1:0] data_out
);

  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Next-state: pass flags through, hold data unless a new result arrives.
  always_comb begin
    valid_d = valid_in;
    err_d   = err_in;
    data_d  = valid_in ? data_in : data_q;
  end

  // Stage register with synchronous reset so a reset flushes in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  assign valid_out = valid_q;
  assign err_out   = err_q;
  assign data_out  = data_q;

endmodule

// File: rtl/ram_param_rtl.sv
// Parameterised single-clock RAM with byte enables, self-clear after reset,
// range-checked ports, selectable read latency and read-during-write policy.
module ram_param_rtl
  import ram_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 4,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_enb,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                rd_enb,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   data_out,
  output logic                rd_valid,
  output logic                rd_err,
  output logic                wr_err,
  output logic                init_busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_CMP = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);

  // Refuse to build with an unsupported parameter set.
  if (!params_ok(DATA_W, DEPTH, ADDR_W, RD_LAT)) begin : g_param_check
    $error("ram_param_rtl: illegal parameter combination");
  end

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic              rd_valid1_q, rd_valid1_d;
  logic              rd_err1_q, rd_err1_d;
  logic [DATA_W-1:0] rd_data1_q, rd_data1_d;
  logic              wr_err_q, wr_err_d;

  // NOTE: the array has no reset; it is cleared word by word by the INIT
  // state instead, which keeps it mappable onto plain RAM.
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              wr_in_range, rd_in_range;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [DATA_W-1:0] wr_merged;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_CMP);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_CMP);
  assign wr_idx      = wr_addr[IDX_W-1:0];
  assign rd_idx      = rd_addr[IDX_W-1:0];

  // Post-write word: old word with enabled bytes replaced by data_in.
  always_comb begin
    wr_merged = mem_q[wr_idx];
    for (int i = 0; i < BE_W; i++) begin
      if (wr_be[i]) wr_merged[i*8 +: 8] = data_in[i*8 +: 8];
    end
  end

  // Control FSM next-state, memory write port and first read stage.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    mem_we      = 1'b0;
    mem_waddr   = wr_idx;
    mem_wdata   = wr_merged;
    rd_valid1_d = 1'b0;
    rd_err1_d   = 1'b0;
    rd_data1_d  = rd_data1_q;
    wr_err_d    = 1'b0;

    if (state_q == ST_INIT) begin
      // Clear one word per cycle; user requests are ignored here.
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
      if (clr_cnt_q == LAST_IDX) state_d = ST_READY;
      else                       clr_cnt_d = clr_cnt_q + 1'b1;
    end else begin
      if (wr_enb) begin
        if (wr_in_range) mem_we   = 1'b1;
        else             wr_err_d = 1'b1;
      end
      if (rd_enb) begin
        rd_valid1_d = 1'b1;
        rd_err1_d   = !rd_in_range;
        if (!rd_in_range)
          rd_data1_d = '0;
        else if (RDW_MODE == RDW_WRITE_FIRST && wr_enb && wr_in_range &&
                 wr_idx == rd_idx)
          rd_data1_d = wr_merged;
        else
          rd_data1_d = mem_q[rd_idx];
      end
    end
  end

  // Control and first-stage read registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= ST_INIT;
      clr_cnt_q   <= '0;
      rd_valid1_q <= 1'b0;
      rd_err1_q   <= 1'b0;
      rd_data1_q  <= '0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      rd_valid1_q <= rd_valid1_d;
      rd_err1_q   <= rd_err1_d;
      rd_data1_q  <= rd_data1_d;
      wr_err_q    <= wr_err_d;
    end
  end

  // Storage array write port; writes are blocked while reset is asserted.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[mem_waddr] <= mem_wdata;
  end

  if (RD_LAT == 2) begin : g_lat2
    ram_rd_pipe #(.DATA_W(DATA_W)) u_rd_pipe (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (rd_valid1_q),
      .err_in    (rd_err1_q),
      .data_in   (rd_data1_q),
      .valid_out (rd_valid),
      .err_out   (rd_err),
      .data_out  (data_out)
    );
  end else begin : g_lat1
    assign rd_valid = rd_valid1_q;
    assign rd_err   = rd_err1_q;
    assign data_out = rd_data1_q;
  end

  assign wr_err    = wr_err_q;
  assign init_busy = (state_q == ST_INIT);

endmodule

// File: doc/ram_param_rtl.md
RAM_PARAM_RTL -- requirements
Module: ram_param_rtl

Interface
REQ-001 Parameters, one per line (name, default, meaning); the ports follow from REQ-007:
- DATA_W, 32, word width in bits; SHALL be a multiple of 8.
- DEPTH, 8, number of words; SHALL be <= 2**ADDR_W.
- ADDR_W, 4, address port width.
- RD_LAT, 1, read latency in cycles; legal values are 1 and 2.
- RDW_MODE, 0, same-address read-during-write policy; 0 = read-first (old data), 1 = write-first (new data).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 wr_enb  input  1  write request; wr_addr  input  ADDR_W  write address; wr_be  input  DATA_W/8  byte enables; data_in  input  DATA_W  write data.
REQ-005 rd_enb  input  1  read request; rd_addr  input  ADDR_W  read address.
REQ-006 data_out  output  DATA_W  read data; rd_valid  output  1  data_out valid pulse; rd_err  output  1  out-of-range read flag; wr_err  output  1  out-of-range write flag; init_busy  output  1  memory clear in progress.
REQ-007 One clock; reset is synchronous and active-high; the ports are named clk and rst.

Function
REQ-008 The control FSM SHALL have two states: INIT and READY. rst forces INIT. INIT moves to READY after the cycle that clears word DEPTH-1.
REQ-009 In INIT, one word per cycle SHALL be written to zero, at addresses 0..DEPTH-1 in ascending order. Clearing SHALL take exactly DEPTH cycles after rst deasserts. init_busy SHALL be 1 throughout INIT.
REQ-010 In INIT, rd_enb and wr_enb SHALL be ignored: no write, no rd_valid, no error flags.
REQ-011 In READY with wr_enb=1 and wr_addr<DEPTH, byte i of mem[wr_addr] SHALL take byte i of data_in wherever wr_be[i]=1. Other bytes SHALL be unchanged.
REQ-012 In READY with wr_enb=1 and wr_addr>=DEPTH, no location SHALL change. wr_err SHALL pulse high for one cycle, in the cycle after the request.
REQ-013 In READY, a read sampled at edge N SHALL produce data_out and a one-cycle rd_valid pulse after edge N+RD_LAT.
REQ-014 For rd_addr>=DEPTH, data_out SHALL be 0 and rd_err SHALL pulse together with rd_valid.
REQ-015 Back-to-back reads SHALL be accepted every cycle, with full throughput and in-order results.
REQ-016 data_out SHALL hold its last value while rd_valid=0.
REQ-017 For a read and write to the same in-range address at the same edge:
- RDW_MODE=0 returns the pre-write word.
- RDW_MODE=1 returns the post-write word, including byte-enable merging.
REQ-018 A read and a write to different addresses at the same edge SHALL both complete with no interaction.
REQ-019 wr_be = 0 with wr_enb=1 SHALL be a legal no-op write, and SHALL NOT raise wr_err for an in-range address.

Reset
REQ-020 When rst=1 at an edge, the block SHALL set: data_out=0, rd_valid=0, rd_err=0, wr_err=0, FSM=INIT, clear counter=0.
REQ-021 init_busy SHALL read 1 in the cycle after any edge with rst=1.
REQ-022 rst asserted during INIT SHALL restart clearing from address 0.
REQ-023 rst asserted during READY SHALL flush the read pipeline: no rd_valid may emerge for reads accepted before reset.

Structure
REQ-024 A shared package ram_pkg SHALL hold:
- the FSM state enum (ST_INIT, ST_READY);
- the RDW_MODE constants (RDW_READ_FIRST=0, RDW_WRITE_FIRST=1).
REQ-025 The optional second read stage (RD_LAT=2) SHALL be a single sub-module, ram_rd_pipe. It carries data, valid and err, and has a synchronous reset.
REQ-026 An illegal parameter combination SHALL fail elaboration. Illegal means any of: DATA_W%8!=0, DEPTH>2**ADDR_W, RD_LAT outside {1,2}.

Verification
REQ-027 Init:
- Stimulus: pulse rst for one cycle (defaults), then drive rd_enb=1, rd_addr=3 every cycle.
- Required: init_busy=1 for exactly 8 cycles and no rd_valid during that time; first rd_valid one cycle after READY, with data_out=0.
REQ-028 Byte enables:
- Stimulus: write 0xAABBCCDD to addr 2 with wr_be=4'hF, then 0x11223344 with wr_be=4'b0101, then read addr 2.
- Required: data_out=0xAA22CC44, rd_valid high one cycle after the read (two cycles with RD_LAT=2).
REQ-029 Read-during-write:
- Stimulus: mem[5]=0x0000_0001; same-edge read and write of addr 5 with data 0x0000_0002, wr_be=4'hF.
- Required: data_out=0x1 with RDW_MODE=0; data_out=0x2 with RDW_MODE=1.
REQ-030 Out of range:
- Stimulus: write addr 9; read addr 12.
- Required: wr_err pulses one cycle after the write and no location changes; rd_valid=1, rd_err=1 and data_out=0 at the read latency.
REQ-031 Reset:
- Stimulus: reset mid-INIT at cycle 4; separately, reset asserted with 2 reads in flight (RD_LAT=2).
- Required: clearing restarts and init_busy lasts 8 cycles after the last rst; no rd_valid from the flushed reads.
